// File: rtl/rnd_sum_datapath_if.sv
// rnd_sum_datapath_if: decoder strobes, seed operand and result handshake of the RND datapath
interface rnd_sum_datapath_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] seed_in;
  logic mux_y_select;
  logic sum_y_prime_sload;
  logic final_sum_sload;
  logic result_ack;
  logic [WIDTH-1:0] y_prime_out;
  logic [WIDTH-1:0] sum_out;
  logic [WIDTH-1:0] final_sum_out;
  logic result_valid;
  logic sum_overflow;
  logic [CNT_W-1:0] round_count;
  modport master (
    output seed_in, mux_y_select, sum_y_prime_sload, final_sum_sload, result_ack,
    input y_prime_out, sum_out, final_sum_out, result_valid, sum_overflow, round_count
  );
  modport slave (
    input seed_in, mux_y_select, sum_y_prime_sload, final_sum_sload, result_ack,
    output y_prime_out, sum_out, final_sum_out, result_valid, sum_overflow, round_count
  );
endinterface

// File: rtl/rnd_sum_datapath.sv
// rnd_sum_datapath: xorshift16 round iterator with running sum and handshaked final result
module rnd_sum_datapath #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] ZERO_SUB = 16'hACE1,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset,
  rnd_sum_datapath_if.slave bus
);
  logic [WIDTH-1:0] y_prime_q, y_prime_d, sum_q, sum_d, final_q, final_d, y_src, y_rnd;
  logic [WIDTH:0] add;
  logic ovf_q, ovf_d, valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  function automatic logic [WIDTH-1:0] round_f(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] t;
    t = x ^ (x << 7);
    t = t ^ (t >> 9);
    return t ^ (t << 8);
  endfunction
  // Y source select, one xorshift round and next state of every register
  always_comb begin
    y_src = bus.mux_y_select ? (bus.seed_in == '0 ? ZERO_SUB : bus.seed_in) : y_prime_q;
    y_rnd = round_f(y_src);
    add = {1'b0, sum_q} + {1'b0, y_rnd};
    y_prime_d = bus.sum_y_prime_sload ? y_rnd : bus.mux_y_select ? y_src : y_prime_q;
    sum_d = bus.sum_y_prime_sload ? (bus.mux_y_select ? y_rnd : add[WIDTH-1:0]) : bus.mux_y_select ? '0 : sum_q;
    ovf_d = bus.mux_y_select ? 1'b0 : bus.sum_y_prime_sload ? (ovf_q | add[WIDTH]) : ovf_q;
    cnt_d = bus.sum_y_prime_sload ? (bus.mux_y_select ? CNT_W'(1) : cnt_q + CNT_W'(cnt_q != '1)) : bus.mux_y_select ? '0 : cnt_q;
    final_d = bus.final_sum_sload ? sum_d : final_q;
    valid_d = bus.final_sum_sload | (valid_q & ~bus.result_ack);
  end
  // State registers; reset overrides every strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      y_prime_q <= '0;
      sum_q <= '0;
      final_q <= '0;
      ovf_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      y_prime_q <= y_prime_d;
      sum_q <= sum_d;
      final_q <= final_d;
      ovf_q <= ovf_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.y_prime_out = y_prime_q;
  assign bus.sum_out = sum_q;
  assign bus.final_sum_out = final_q;
  assign bus.result_valid = valid_q;
  assign bus.sum_overflow = ovf_q;
  assign bus.round_count = cnt_q;
endmodule

// File: tb/tb_rnd_sum_datapath.sv
// tb_rnd_sum_datapath: scoreboard bench with a behavioural model of the RND datapath
module tb_rnd_sum_datapath;
  typedef struct {
    logic [15:0] yp;
    logic [15:0] sum;
    logic [15:0] fin;
    logic val;
    logic ovf;
    logic [3:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  exp_t q[$];
  int m_yp, m_sum, m_fin, m_cnt;
  bit m_val, m_ovf;
  rnd_sum_datapath_if #(.WIDTH(16), .CNT_W(4)) bus ();
  rnd_sum_datapath dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic int xs(input int v);
    int x;
    x = v;
    x = (x ^ (x * 128)) % 65536;
    x = x ^ (x / 512);
    x = (x ^ (x * 256)) % 65536;
    return x;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step(input logic r, input logic [15:0] s, input logic mux, input logic sl, input logic fs, input logic ack);
    int ys, v, nsum;
    exp_t e;
    @(negedge clk);
    reset = r;
    bus.seed_in = s;
    bus.mux_y_select = mux;
    bus.sum_y_prime_sload = sl;
    bus.final_sum_sload = fs;
    bus.result_ack = ack;
    if (r) begin
      m_yp = 0; m_sum = 0; m_fin = 0; m_cnt = 0; m_val = 0; m_ovf = 0;
    end else begin
      ys = mux ? (s == 0 ? 'hACE1 : int'(s)) : m_yp;
      nsum = m_sum;
      if (sl) begin
        v = xs(ys);
        m_yp = v;
        if (mux) begin
          nsum = v; m_ovf = 0; m_cnt = 1;
        end else begin
          nsum = (m_sum + v) % 65536;
          m_ovf = m_ovf | (m_sum + v > 65535);
          m_cnt = m_cnt < 15 ? m_cnt + 1 : 15;
        end
      end else if (mux) begin
        m_yp = ys; nsum = 0; m_ovf = 0; m_cnt = 0;
      end
      m_sum = nsum;
      if (fs) begin
        m_fin = nsum; m_val = 1;
      end else if (ack) m_val = 0;
    end
    e.yp = 16'(m_yp); e.sum = 16'(m_sum); e.fin = 16'(m_fin);
    e.val = m_val; e.ovf = m_ovf; e.cnt = 4'(m_cnt);
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("y_prime", 32'(bus.y_prime_out), 32'(e.yp));
        chk("sum", 32'(bus.sum_out), 32'(e.sum));
        chk("final_sum", 32'(bus.final_sum_out), 32'(e.fin));
        chk("result_valid", 32'(bus.result_valid), 32'(e.val));
        chk("sum_overflow", 32'(bus.sum_overflow), 32'(e.ovf));
        chk("round_count", 32'(bus.round_count), 32'(e.cnt));
      end
    end
  end
  initial begin
    logic [15:0] held;
    bus.seed_in = '0;
    bus.mux_y_select = 0;
    bus.sum_y_prime_sload = 0;
    bus.final_sum_sload = 0;
    bus.result_ack = 0;
    step(1, 16'h1234, 1, 1, 1, 1);
    step(1, 16'h0000, 0, 0, 0, 0);
    chk("reset_sum", 32'(bus.sum_out), 0);
    chk("reset_valid", 32'(bus.result_valid), 0);
    step(0, 16'h0001, 1, 0, 0, 0);
    step(0, 16'h0001, 0, 1, 0, 0);
    chk("t2_yp", 32'(bus.y_prime_out), 32'h8181);
    chk("t2_sum", 32'(bus.sum_out), 32'h8181);
    chk("t2_cnt", 32'(bus.round_count), 1);
    step(0, 16'h0001, 0, 1, 1, 0);
    chk("t3_yp", 32'(bus.y_prime_out), 32'h6021);
    chk("t3_sum", 32'(bus.sum_out), 32'hE1A2);
    chk("t3_final", 32'(bus.final_sum_out), 32'hE1A2);
    chk("t3_valid", 32'(bus.result_valid), 1);
    chk("t3_cnt", 32'(bus.round_count), 2);
    chk("t3_ovf", 32'(bus.sum_overflow), 0);
    step(0, 16'h5A5A, 0, 1, 0, 0);
    step(1, 16'h7777, 1, 1, 1, 0);
    chk("t1_yp", 32'(bus.y_prime_out), 0);
    chk("t1_sum", 32'(bus.sum_out), 0);
    chk("t1_final", 32'(bus.final_sum_out), 0);
    chk("t1_valid", 32'(bus.result_valid), 0);
    chk("t1_cnt", 32'(bus.round_count), 0);
    step(0, 16'h0000, 1, 0, 0, 0);
    chk("t4_yp", 32'(bus.y_prime_out), 32'hACE1);
    for (int i = 0; i < 8; i++) step(0, 16'hFFFF, 0, 1, 0, 0);
    step(0, 16'h0000, 0, 1, 1, 0);
    chk("t5_valid_a", 32'(bus.result_valid), 1);
    step(0, 16'h0000, 0, 1, 1, 1);
    chk("t5_valid_b", 32'(bus.result_valid), 1);
    chk("t5_final_new", 32'(bus.final_sum_out), 32'(m_sum));
    held = bus.final_sum_out;
    step(0, 16'h0000, 0, 0, 0, 1);
    chk("t5_valid_c", 32'(bus.result_valid), 0);
    chk("t5_final_held", 32'(bus.final_sum_out), 32'(held));
    step(0, 16'h0000, 0, 0, 0, 1);
    chk("t5_ack_idle", 32'(bus.result_valid), 0);
    step(0, 16'hBEEF, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 16'h0000, 0, 1, 0, 0);
    chk("t6_sat", 32'(bus.round_count), 15);
    step(0, 16'h1357, 1, 1, 0, 0);
    chk("t6_reload", 32'(bus.round_count), 1);
    chk("t6_ovf_clr", 32'(bus.sum_overflow), 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0 ? 16'h0000 : 16'($urandom),
           $urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 4) == 0, 1'($urandom));
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rnd_sum_datapath.md
Name: rnd_sum_datapath

Overview:
Datapath stage directly downstream of the RND instruction decoder. It consumes the decoder's Y-select, Sum/Y_Prime load and Final_Sum load strobes to iterate a xorshift16 pseudo-random round. It accumulates a running sum of the round outputs and latches the final result when the loop condition is met. The result is held with a valid/ack handshake for the accumulator write-back path.

Parameters:
WIDTH, 16, data width of seed, Y_Prime, sum and result registers (round function is defined for 16 only).
ZERO_SUB, 16'hACE1, substitute seed used when seed_in is zero (xorshift lock-up avoidance).
CNT_W, 4, width of round counter.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
seed_in  input  WIDTH  seed operand from accumulator/memory data.
mux_y_select  input  1  1: Y source = seed; 0: Y source = y_prime register.
sum_y_prime_sload  input  1  perform one round: load y_prime and update sum.
final_sum_sload  input  1  latch final result (decoder Cond_Met).
result_ack  input  1  consumer has taken final_sum_out; clears result_valid.
y_prime_out  output  WIDTH  current y_prime register.
sum_out  output  WIDTH  running sum register.
final_sum_out  output  WIDTH  latched final result.
result_valid  output  1  final_sum_out holds an unconsumed result.
sum_overflow  output  1  sticky: carry out of sum occurred in current instruction.
round_count  output  CNT_W  rounds performed since last seed load, saturating.

Behaviour:
- Reset (sync, high): all registers and outputs are 0. This takes priority over every strobe, including mid-operation.
- Y source (comb): y_src = mux_y_select ? (seed_in==0 ? ZERO_SUB : seed_in) : y_prime register.
- Round r(x) (comb, 16-bit, truncating): x^=x<<7; x^=x>>9; x^=x<<8.
- sum_y_prime_sload=1 at edge:
  - y_prime <= r(y_src).
  - If mux_y_select=1 (first round of a new instruction): sum <= r(y_src), sum_overflow <= 0, round_count <= 1.
  - Otherwise: sum <= sum + r(y_src) mod 2^WIDTH; sum_overflow |= carry; round_count <= min(round_count+1, 2^CNT_W-1).
- mux_y_select=1 with sum_y_prime_sload=0 (decoder Exec1 seed phase):
  - y_prime <= y_src (seed staged).
  - sum, sum_overflow and round_count <= 0.
- final_sum_sload=1:
  - final_sum_out <= the value sum takes at this same edge. If a round fires in the same cycle, this is the new sum; otherwise it is the current sum.
  - result_valid <= 1.
- result_ack=1 with result_valid=1 and final_sum_sload=0: result_valid <= 0. A simultaneous final_sum_sload wins, so valid stays 1 with the new value.
- result_ack while result_valid=0: no effect.
- A new final_sum_sload while result_valid=1 overwrites final_sum_out (no back-pressure; the decoder cannot stall).
- No strobes: all registers hold.
- Latency: one clock from strobe to register output; no combinational path from strobes to outputs.

Test Plan:
1. Reset mid-run: after 3 rounds assert reset 1 cycle -> all outputs 0 next edge; strobes asserted during reset are ignored.
2. seed_in=0x0001, cycle A {mux_y_select=1, sum_y_prime_sload=0} then cycle B {mux_y_select=0, sload=1} -> y_prime=0x8181, sum=0x8181, round_count=1.
3. Continue from 2: one more round with final_sum_sload=1 in the same cycle -> y_prime=0x6021, sum=0xE1A2, final_sum_out=0xE1A2, result_valid=1, round_count=2, sum_overflow=0.
4. seed_in=0x0000 with mux_y_select=1 -> y_prime=0xACE1. Then 8 rounds: check against reference model, and sum_overflow set iff any 16-bit add carried.
5. result_valid=1, assert result_ack and final_sum_sload together -> result_valid stays 1 with the new value. Next cycle ack alone -> result_valid=0, and final_sum_out holds its value.
6. 20 consecutive rounds after one seed load -> round_count saturates at 15. A new seed load with a round resets it to 1.
